// File: rtl/fir_tap_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_tap_scheduler_if                                          |
// | Purpose  : Bundles the sample handshake, coefficient write port, MAC     |
// |            operand/accumulator bus and filter output of the FIR tap      |
// |            scheduler.                                                    |
// | Modports : slave  - the scheduler (consumes samples, drives MAC/output)  |
// |            master - the surrounding system (sample source, MAC, sink)    |
// | Signals  : ena, s_valid/s_ready/s_data, coef_we/coef_addr/coef_data,     |
// |            coef_err, mac_clr/mac_en/mac_x/mac_h, mac_acc,                |
// |            y_valid/y_data, busy                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fir_tap_scheduler_if #(
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int ACCW = 2*DW+AW
) ();
  logic            ena;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [DW-1:0]   coef_data;
  logic            coef_err;
  logic            mac_clr;
  logic            mac_en;
  logic [DW-1:0]   mac_x;
  logic [DW-1:0]   mac_h;
  logic [ACCW-1:0] mac_acc;
  logic            y_valid;
  logic [ACCW-1:0] y_data;
  logic            busy;

  modport slave (
    input  ena, s_valid, s_data, coef_we, coef_addr, coef_data, mac_acc,
    output s_ready, coef_err, mac_clr, mac_en, mac_x, mac_h, y_valid, y_data, busy
  );

  modport master (
    output ena, s_valid, s_data, coef_we, coef_addr, coef_data, mac_acc,
    input  s_ready, coef_err, mac_clr, mac_en, mac_x, mac_h, y_valid, y_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_tap_scheduler                                             |
// | Purpose  : Sequencer for a time-multiplexed FIR. Accepts one sample per  |
// |            handshake into a delay line, then streams NTAPS (x[k], h[k])  |
// |            pairs to a shared external MAC and captures its accumulator   |
// |            as the filter output. Owns the coefficient register file.     |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst_n  - asynchronous active-low reset                        |
// |            bus    - fir_tap_scheduler_if.slave (handshake, coef port,    |
// |                     MAC bus, output, ena, busy)                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fir_tap_scheduler #(
  parameter int NTAPS = 8,
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int ACCW  = 2*DW+AW
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_tap_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;

  logic [DW-1:0]   x_q [NTAPS];
  logic [DW-1:0]   h_q [NTAPS];

  logic            mac_en_q, mac_clr_q, y_valid_q, coef_err_q;
  logic [DW-1:0]   mac_x_q, mac_h_q;
  logic [ACCW-1:0] y_data_q;

  logic            is_idle;
  logic            s_ready;
  logic            accept;
  logic            k_last;
  logic            coef_in_range;
  logic [AW-1:0]   k_nxt;

  assign is_idle       = (state_q == S_IDLE);
  assign s_ready       = bus.ena & is_idle;
  assign accept        = bus.s_valid & s_ready;
  assign k_last        = (k_q == AW'(NTAPS-1));
  // Only consumed while k_q < NTAPS-1, so it never points past the last tap.
  assign k_nxt         = k_q + AW'(1);
  assign coef_in_range = ({1'b0, bus.coef_addr} < (AW+1)'(NTAPS));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_RUN;
            k_d     = '0;
          end
        end
        S_RUN: begin
          if (k_last) state_d = S_WAIT;
          else        k_d     = k_nxt;
        end
        S_WAIT:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  // The MAC operand registers are loaded one edge ahead of the tap they
  // present: the accept edge loads tap 0, each RUN edge loads tap k+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_x_q    <= '0;
      mac_h_q    <= '0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
      coef_err_q <= 1'b0;
    end else if (bus.ena) begin
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;

      if (bus.coef_we) begin
        if (!is_idle)           coef_err_q          <= 1'b1;
        else if (coef_in_range) h_q[bus.coef_addr]  <= bus.coef_data;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q[0] <= bus.s_data;
            for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
            mac_en_q  <= 1'b1;
            mac_clr_q <= 1'b1;
            mac_x_q   <= bus.s_data;
            // A coincident write to h[0] must be visible on the first tap.
            mac_h_q   <= (bus.coef_we && coef_in_range && bus.coef_addr == '0)
                         ? bus.coef_data : h_q[0];
          end
        end
        S_RUN: begin
          if (!k_last) begin
            mac_en_q <= 1'b1;
            mac_x_q  <= x_q[k_nxt];
            mac_h_q  <= h_q[k_nxt];
          end
        end
        S_WAIT: begin
          y_data_q  <= bus.mac_acc;
          y_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pulses are held frozen while ena is low and only shown once ena returns,
  // so the MAC never sees the same operand pair twice across a freeze.
  assign bus.s_ready  = s_ready;
  assign bus.mac_en   = mac_en_q & bus.ena;
  assign bus.y_valid  = y_valid_q & bus.ena;
  assign bus.coef_err = coef_err_q & bus.ena;
  assign bus.mac_clr  = mac_clr_q;
  assign bus.mac_x    = mac_x_q;
  assign bus.mac_h    = mac_h_q;
  assign bus.y_data   = y_data_q;
  assign bus.busy     = ~is_idle;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_tap_scheduler                                          |
// | Purpose  : Self-checking bench for fir_tap_scheduler with a behavioural  |
// |            MAC and a cycle-level reference model of the filter.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fir_tap_scheduler;
  localparam int NTAPS = 8;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int ACCW  = 2*DW+AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_tap_scheduler_if #(.DW(DW), .AW(AW), .ACCW(ACCW)) bus ();

  fir_tap_scheduler #(.NTAPS(NTAPS), .DW(DW), .AW(AW), .ACCW(ACCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------ behavioural MAC
  logic [ACCW-1:0] prod;
  assign prod = ACCW'($signed(bus.mac_x)) * ACCW'($signed(bus.mac_h));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bus.mac_acc <= '0;
    else if (bus.mac_en) bus.mac_acc <= bus.mac_clr ? prod : bus.mac_acc + prod;
  end

  // ------------------------------------------------ reference model
  // m_cnt counts enabled edges since the model accepted a sample:
  // 1..NTAPS operand cycles, NTAPS+1 waiting, NTAPS+2 output cycle.
  logic [DW-1:0]   m_hist [NTAPS];
  logic [DW-1:0]   m_coef [NTAPS];
  bit              m_fly;
  int              m_cnt;
  bit              m_err;
  int              m_nacc;
  logic [ACCW-1:0] m_y_exp, m_y_last;

  int              cyc = 0, acc_cyc = 0, yv_cyc = 0, err_seen = 0;
  logic [ACCW-1:0] yq [$];
  int              accq [$];

  always @(negedge clk) begin : mon
    bit busy_e, run_e;
    int s;
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        m_hist[k] = '0;
        m_coef[k] = '0;
      end
      m_fly = 0; m_cnt = 0; m_err = 0; m_y_last = '0;
      chk("rst_busy",    bus.busy,    0);
      chk("rst_mac_en",  bus.mac_en,  0);
      chk("rst_y_valid", bus.y_valid, 0);
      chk("rst_y_data",  bus.y_data,  0);
      chk("rst_ready",   bus.s_ready, bus.ena);
    end else begin
      busy_e = m_fly && m_cnt >= 1 && m_cnt <= NTAPS+1;
      run_e  = m_fly && m_cnt >= 1 && m_cnt <= NTAPS;
      chk("busy",     bus.busy,     busy_e);
      chk("s_ready",  bus.s_ready,  bus.ena && !busy_e);
      chk("mac_en",   bus.mac_en,   bus.ena && run_e);
      chk("y_valid",  bus.y_valid,  bus.ena && m_fly && m_cnt == NTAPS+2);
      chk("y_data",   bus.y_data,   m_y_last);
      chk("coef_err", bus.coef_err, bus.ena && m_err);
      if (run_e && bus.ena) begin
        chk("mac_x",   bus.mac_x,   m_hist[m_cnt-1]);
        chk("mac_h",   bus.mac_h,   m_coef[m_cnt-1]);
        chk("mac_clr", bus.mac_clr, m_cnt == 1);
      end
      if (bus.y_valid) begin yq.push_back(bus.y_data); yv_cyc = cyc; end
      if (bus.s_valid && bus.s_ready) begin accq.push_back(cyc); acc_cyc = cyc; end
      if (bus.coef_err) err_seen++;

      if (bus.ena) begin
        m_err = bus.coef_we && busy_e;
        if (bus.coef_we && !busy_e && int'(bus.coef_addr) < NTAPS)
          m_coef[bus.coef_addr] = bus.coef_data;
        if (m_fly && m_cnt == NTAPS+2) m_fly = 0;
        if (bus.s_valid && !busy_e) begin
          for (int k = NTAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
          m_hist[0] = bus.s_data;
          s = 0;
          for (int k = 0; k < NTAPS; k++)
            s += int'($signed(m_coef[k])) * int'($signed(m_hist[k]));
          m_y_exp = s[ACCW-1:0];
          m_fly   = 1;
          m_cnt   = 1;
          m_nacc++;
        end else if (m_fly) begin
          m_cnt++;
          if (m_cnt == NTAPS+2) m_y_last = m_y_exp;
        end
      end
    end
  end

  // ------------------------------------------------ stimulus helpers
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; bus.s_valid = 1'b0; bus.coef_we = 1'b0; bus.ena = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wr_coef(input int a, input logic [DW-1:0] d);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(a); bus.coef_data = d;
    tick(1);
    bus.coef_we = 1'b0;
  endtask

  task automatic load_ramp;
    for (int k = 0; k < NTAPS; k++) wr_coef(k, DW'(k+1));
  endtask

  // Presents a sample and holds it until accepted; returns in cycle T+1.
  task automatic send(input logic [DW-1:0] d, input bit keep);
    bit got = 0;
    int n = 0;
    bus.s_valid = 1'b1; bus.s_data = d;
    while (!got && n < 40) begin
      @(negedge clk);
      got = bus.s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!got) chk("send_timeout", 0, 1);
    if (!keep) bus.s_valid = 1'b0;
  endtask

  // Sample and coefficient write presented in the same cycle once idle.
  task automatic send_wr(input logic [DW-1:0] d, input int a, input logic [DW-1:0] c);
    int n = 0;
    while (!bus.s_ready && n < 40) begin tick(1); n++; end
    if (!bus.s_ready) chk("send_wr_timeout", 0, 1);
    bus.s_valid = 1'b1; bus.s_data = d;
    bus.coef_we = 1'b1; bus.coef_addr = AW'(a); bus.coef_data = c;
    tick(1);
    bus.s_valid = 1'b0; bus.coef_we = 1'b0;
  endtask

  // ------------------------------------------------ test sequence
  initial begin : stim
    int base, ab, e0, nb;
    bit acc;
    logic [ACCW-1:0] neg4;
    neg4 = ACCW'(-4);
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;

    // 1: zero coefficients, one sample
    do_reset;
    chk("t1_ready", bus.s_ready, 1);
    chk("t1_mac_en", bus.mac_en, 0);
    base = yq.size();
    send(8'd5, 0);
    tick(12);
    chk("t1_count", yq.size() - base, 1);
    if (yq.size() > base) chk("t1_y", yq[base], 0);
    chk("t1_latency", yv_cyc - acc_cyc, 10);

    // 2: impulse response of ramp coefficients
    do_reset; load_ramp;
    base = yq.size();
    send(8'd1, 0);
    for (int i = 0; i < 7; i++) send(8'd0, 0);
    tick(12);
    chk("t2_count", yq.size() - base, 8);
    if (yq.size() >= base + 8)
      for (int i = 0; i < 8; i++) chk("t2_y", yq[base+i], i+1);
    chk("t2_latency", yv_cyc - acc_cyc, 10);

    // 3: s_valid held high, pass-through coefficient
    do_reset; wr_coef(0, 8'd1);
    base = yq.size(); ab = accq.size();
    for (int i = 1; i <= 6; i++) send(DW'(i), i < 6);
    tick(12);
    chk("t3_count", yq.size() - base, 6);
    if (yq.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("t3_y", yq[base+i], i+1);
    if (accq.size() >= ab + 6)
      for (int i = 0; i < 5; i++) chk("t3_gap", accq[ab+i+1] - accq[ab+i], 10);

    // 4a: write during RUN is dropped and flagged
    do_reset; load_ramp;
    base = yq.size();
    send(8'd1, 0); send(8'd0, 0); send(8'd0, 0); send(8'd0, 0);
    tick(2);
    e0 = err_seen;
    wr_coef(3, 8'hFC);
    tick(12);
    chk("t4_err_pulse", err_seen - e0, 1);
    if (yq.size() >= base + 4) chk("t4_old_h3", yq[base+3], 4);
    else chk("t4_count", yq.size() - base, 4);

    // 4b: write in IDLE coincident with accept takes effect
    do_reset; load_ramp;
    base = yq.size();
    send(8'd1, 0); send(8'd0, 0); send(8'd0, 0);
    send_wr(8'd0, 3, 8'hFC);
    tick(12);
    if (yq.size() >= base + 4) chk("t4_new_h3", yq[base+3], neg4);
    else chk("t4b_count", yq.size() - base, 4);

    // 5: freeze three cycles mid-RUN
    do_reset; load_ramp;
    base = yq.size();
    send(8'd1, 0);
    tick(2);
    bus.ena = 1'b0;
    tick(3);
    bus.ena = 1'b1;
    tick(12);
    chk("t5_latency", yv_cyc - acc_cyc, 13);
    for (int i = 0; i < 7; i++) send(8'd0, 0);
    tick(12);
    chk("t5_count", yq.size() - base, 8);
    if (yq.size() >= base + 8)
      for (int i = 0; i < 8; i++) chk("t5_y", yq[base+i], i+1);

    // 6: reset mid-operation
    do_reset; load_ramp;
    base = yq.size();
    send(8'd1, 0);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(15);
    chk("t6_no_output", yq.size() - base, 0);
    load_ramp;
    base = yq.size();
    send(8'd1, 0);
    for (int i = 0; i < 7; i++) send(8'd0, 0);
    tick(12);
    chk("t6_count", yq.size() - base, 8);
    if (yq.size() >= base + 8)
      for (int i = 0; i < 8; i++) chk("t6_y", yq[base+i], i+1);

    // Random traffic: samples, enables and coefficient writes
    do_reset;
    for (int k = 0; k < NTAPS; k++) wr_coef(k, DW'($urandom));
    base = yq.size(); nb = m_nacc;
    acc = 0;
    for (int i = 0; i < 800; i++) begin
      if (!bus.s_valid || acc) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = DW'($urandom);
      end
      bus.ena       = ($urandom_range(0, 9) != 0);
      bus.coef_we   = ($urandom_range(0, 5) == 0);
      bus.coef_addr = AW'($urandom);
      bus.coef_data = DW'($urandom);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0; bus.coef_we = 1'b0; bus.ena = 1'b1;
    tick(15);
    chk("rnd_outputs", yq.size() - base, m_nacc - nb);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
